// File: rtl/mag_pkg.sv
// Shared types and constants for the magnitude envelope tracker.
package mag_pkg;

  localparam int MAG_W            = 8;
  localparam int AVG_LOG2_DEFAULT = 3;

  localparam logic [MAG_W-1:0] MAG_ONE = 1;

  typedef enum logic {
    BELOW = 1'b0,
    ABOVE = 1'b1
  } hyst_state_e;

  typedef struct packed {
    logic [MAG_W-1:0] peak;
    logic [MAG_W-1:0] avg;
    logic             above;
    logic             rise;
    logic             fall;
  } beat_t;

  function automatic logic [MAG_W-1:0] mag_max(input logic [MAG_W-1:0] a,
                                               input logic [MAG_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mag_boxcar.sv
// Boxcar history buffer and running sum; avg is the mean including the sample being pushed.
module mag_boxcar
  import mag_pkg::*;
#(
  parameter int AVG_LOG2 = AVG_LOG2_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [MAG_W-1:0] sample,
  output logic [MAG_W-1:0] avg
);

  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SUM_W = MAG_W + AVG_LOG2;
  localparam logic [AVG_LOG2-1:0] PTR_ONE = 1;

  logic [MAG_W-1:0]    hist [DEPTH];
  logic [AVG_LOG2-1:0] wr_ptr;
  logic [SUM_W-1:0]    sum;
  logic [SUM_W-1:0]    sum_next;
  logic [MAG_W-1:0]    oldest;

  // The write pointer always addresses the oldest entry, which the new sample replaces.
  assign oldest   = hist[wr_ptr];
  assign sum_next = sum + SUM_W'(sample) - SUM_W'(oldest);
  assign avg      = sum_next[SUM_W-1:AVG_LOG2];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        hist[i] <= '0;
      end
      wr_ptr <= '0;
      sum    <= '0;
    end else if (push) begin
      hist[wr_ptr] <= sample;
      wr_ptr       <= wr_ptr + PTR_ONE;
      sum          <= sum_next;
    end
  end

endmodule

// File: rtl/mag_envelope_tracker.sv
// Magnitude envelope tracker: peak hold, boxcar mean and hysteresis crossing detection.
// Define MAG_TRACK_DECAY_EN to build in periodic peak decay.
module mag_envelope_tracker
  import mag_pkg::*;
#(
  parameter int AVG_LOG2     = AVG_LOG2_DEFAULT,
  parameter int DECAY_PERIOD = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [MAG_W-1:0] in_mag,
  output logic             in_ready,
  input  logic [MAG_W-1:0] thresh_hi,
  input  logic [MAG_W-1:0] thresh_lo,
  input  logic             clr_peak,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [MAG_W-1:0] out_peak,
  output logic [MAG_W-1:0] out_avg,
  output logic             out_above,
  output logic             out_rise,
  output logic             out_fall
);

  logic             accept;
  logic [MAG_W-1:0] box_avg;
  logic [MAG_W-1:0] peak_q;
  logic [MAG_W-1:0] peak_d;
  hyst_state_e      state_q;
  hyst_state_e      state_d;
  beat_t            beat_q;
  beat_t            beat_d;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  mag_boxcar #(
    .AVG_LOG2(AVG_LOG2)
  ) u_boxcar (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .sample(in_mag),
    .avg   (box_avg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BELOW;
    end else begin
      state_q <= state_d;
    end
  end

  // Thresholds are only consulted on accepted samples, so the state never moves while idle.
  always_comb begin
    state_d = state_q;
    if (accept) begin
      case (state_q)
        BELOW:   if (in_mag >= thresh_hi) state_d = ABOVE;
        ABOVE:   if (in_mag < thresh_lo)  state_d = BELOW;
        default: state_d = BELOW;
      endcase
    end
  end

`ifdef MAG_TRACK_DECAY_EN
  localparam int CNT_W = $clog2(DECAY_PERIOD + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECAY_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = 1;

  logic [CNT_W-1:0] decay_cnt;
  logic [CNT_W-1:0] decay_cnt_d;

  // The counter measures how long the peak has been unchanged; a decay step restarts it.
  always_comb begin
    peak_d      = peak_q;
    decay_cnt_d = decay_cnt + CNT_ONE;
    if (clr_peak) begin
      peak_d      = accept ? in_mag : '0;
      decay_cnt_d = '0;
    end else if (accept && (in_mag > peak_q)) begin
      peak_d      = in_mag;
      decay_cnt_d = '0;
    end else if (decay_cnt == CNT_LAST) begin
      decay_cnt_d = '0;
      if (peak_q != '0) begin
        peak_d = peak_q - MAG_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      decay_cnt <= '0;
    end else begin
      decay_cnt <= decay_cnt_d;
    end
  end
`else
  always_comb begin
    peak_d = peak_q;
    if (clr_peak) begin
      peak_d = accept ? in_mag : '0;
    end else if (accept) begin
      peak_d = mag_max(peak_q, in_mag);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      peak_q <= '0;
    end else begin
      peak_q <= peak_d;
    end
  end

  always_comb begin
    beat_d       = '0;
    beat_d.peak  = peak_d;
    beat_d.avg   = box_avg;
    beat_d.above = (state_d == ABOVE);
    beat_d.rise  = (state_q == BELOW) && (state_d == ABOVE);
    beat_d.fall  = (state_q == ABOVE) && (state_d == BELOW);
  end

  // The output register only loads on accept, so a stalled beat (and its peak) stays frozen.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      beat_q    <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      beat_q    <= beat_d;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign out_peak  = beat_q.peak;
  assign out_avg   = beat_q.avg;
  assign out_above = beat_q.above;
  assign out_rise  = beat_q.rise;
  assign out_fall  = beat_q.fall;

endmodule

// File: tb/tb_mag_envelope_tracker.sv
// Self-checking bench for mag_envelope_tracker: a sample-level reference model plus directed literal checks.
module tb_mag_envelope_tracker;

  localparam int TB_DECAY = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_mag;
  logic       in_ready;
  logic [7:0] thresh_hi;
  logic [7:0] thresh_lo;
  logic       clr_peak;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_peak;
  logic [7:0] out_avg;
  logic       out_above;
  logic       out_rise;
  logic       out_fall;

  int checks = 0;
  int errors = 0;

  int s35[5]       = '{50, 100, 70, 59, 100};
  int above35[5]   = '{0, 1, 1, 0, 1};
  int rise35[5]    = '{0, 1, 0, 0, 1};
  int fall35[5]    = '{0, 0, 0, 1, 0};
  logic [15:0] pat = 16'b1011_0010_1110_0101;

  always #5 clk = ~clk;

  mag_envelope_tracker #(
    .AVG_LOG2    (3),
    .DECAY_PERIOD(TB_DECAY)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_mag   (in_mag),
    .in_ready (in_ready),
    .thresh_hi(thresh_hi),
    .thresh_lo(thresh_lo),
    .clr_peak (clr_peak),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_peak (out_peak),
    .out_avg  (out_avg),
    .out_above(out_above),
    .out_rise (out_rise),
    .out_fall (out_fall)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Reference model: last eight samples kept as a list, peak and hysteresis as plain values.
  int m_hist[$];
  bit m_live = 1'b0;
  bit m_valid, m_above, m_rise, m_fall, m_acc;
  int m_peak, m_cnt, m_out_peak, m_out_avg, m_sum;

  always @(posedge clk) begin
    if (rst) begin
      m_live  = 1'b1;
      m_valid = 1'b0;
      m_above = 1'b0;
      m_rise  = 1'b0;
      m_fall  = 1'b0;
      m_peak  = 0;
      m_cnt   = 0;
      m_out_peak = 0;
      m_out_avg  = 0;
      m_hist.delete();
      repeat (8) m_hist.push_back(0);
    end else if (m_live) begin
      m_acc = in_valid && (!m_valid || out_ready);
      if (clr_peak) begin
        m_peak = m_acc ? int'(in_mag) : 0;
        m_cnt  = 0;
      end else if (m_acc && int'(in_mag) > m_peak) begin
        m_peak = in_mag;
        m_cnt  = 0;
      end
`ifdef MAG_TRACK_DECAY_EN
      else begin
        m_cnt++;
        if (m_cnt == TB_DECAY) begin
          m_cnt = 0;
          if (m_peak > 0) m_peak--;
        end
      end
`endif
      if (m_acc) begin
        void'(m_hist.pop_front());
        m_hist.push_back(in_mag);
        m_sum = 0;
        foreach (m_hist[i]) m_sum += m_hist[i];
        m_out_avg  = m_sum / 8;
        m_out_peak = m_peak;
        m_rise = 1'b0;
        m_fall = 1'b0;
        if (!m_above && in_mag >= thresh_hi) begin
          m_above = 1'b1;
          m_rise  = 1'b1;
        end else if (m_above && in_mag < thresh_lo) begin
          m_above = 1'b0;
          m_fall  = 1'b1;
        end
        m_valid = 1'b1;
      end else if (out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      checkOutput("model_in_ready", in_ready, int'(!m_valid || out_ready));
      checkOutput("model_out_valid", out_valid, int'(m_valid));
      if (m_valid) begin
        checkOutput("model_peak", out_peak, m_out_peak);
        checkOutput("model_avg", out_avg, m_out_avg);
        checkOutput("model_above", out_above, int'(m_above));
        checkOutput("model_rise", out_rise, int'(m_rise));
        checkOutput("model_fall", out_fall, int'(m_fall));
      end
    end
  end

  task automatic doReset();
    rst      = 1'b1;
    in_valid = 1'b0;
    clr_peak = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Holds a sample on the input until the DUT takes it; returns just after the accepting edge.
  task automatic applyStimulus(input logic [7:0] mag, input logic clr);
    bit done = 1'b0;
    in_valid = 1'b1;
    in_mag   = mag;
    clr_peak = clr;
    for (int n = 0; n < 20 && !done; n++) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    clr_peak = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: got no accept, expected accept of %0d", mag);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    in_valid  = 1'b0;
    in_mag    = '0;
    clr_peak  = 1'b0;
    out_ready = 1'b1;
    thresh_hi = 8'd200;
    thresh_lo = 8'd10;
    rst       = 1'b1;

    doReset();
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_peak", out_peak, 0);
    checkOutput("rst_avg", out_avg, 0);
    checkOutput("rst_above", out_above, 0);
    checkOutput("rst_rise", out_rise, 0);
    checkOutput("rst_fall", out_fall, 0);

    for (int k = 1; k <= 8; k++) begin
      applyStimulus(8'd80, 1'b0);
      checkOutput("fill_avg", out_avg, 10 * k);
    end
    checkOutput("fill_peak", out_peak, 80);
    applyStimulus(8'd0, 1'b0);
    checkOutput("ninth_avg", out_avg, 70);
    checkOutput("ninth_peak", out_peak, 80);

    doReset();
    thresh_hi = 8'd100;
    thresh_lo = 8'd60;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(s35[i][7:0], 1'b0);
      checkOutput("hyst_above", out_above, above35[i]);
      checkOutput("hyst_rise", out_rise, rise35[i]);
      checkOutput("hyst_fall", out_fall, fall35[i]);
    end

    doReset();
    out_ready = 1'b0;
    applyStimulus(8'd40, 1'b0);
    in_valid = 1'b1;
    in_mag   = 8'd90;
    repeat (5) begin
      @(posedge clk);
      #1;
      checkOutput("stall_in_ready", in_ready, 0);
      checkOutput("stall_valid", out_valid, 1);
      checkOutput("stall_avg", out_avg, 5);
      checkOutput("stall_peak", out_peak, 40);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    checkOutput("release_avg", out_avg, 16);
    checkOutput("release_peak", out_peak, 90);
    @(posedge clk);
    #1 checkOutput("drain_valid", out_valid, 0);

    doReset();
    applyStimulus(8'd200, 1'b0);
    checkOutput("peak_200", out_peak, 200);
    applyStimulus(8'd30, 1'b1);
    checkOutput("clr_with_sample", out_peak, 30);
    clr_peak = 1'b1;
    @(posedge clk);
    #1 clr_peak = 1'b0;
    applyStimulus(8'd10, 1'b0);
    checkOutput("clr_alone_next", out_peak, 10);

    doReset();
    thresh_hi = 8'd50;
    thresh_lo = 8'd150;
    applyStimulus(8'd100, 1'b0);
    checkOutput("inv_rise", out_rise, 1);
    checkOutput("inv_above1", out_above, 1);
    applyStimulus(8'd100, 1'b0);
    checkOutput("inv_fall", out_fall, 1);
    checkOutput("inv_above2", out_above, 0);
    applyStimulus(8'd100, 1'b0);
    checkOutput("inv_rise_again", out_rise, 1);

    doReset();
    thresh_hi = 8'd100;
    thresh_lo = 8'd60;
    for (int c = 0; c < 48; c++) begin
      out_ready = pat[c % 16];
      in_valid  = (c % 3) != 2;
      in_mag    = 8'((c * 37) % 256);
      clr_peak  = (c == 20);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    clr_peak  = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    doReset();
    applyStimulus(8'd5, 1'b0);
    checkOutput("hold_start_peak", out_peak, 5);
    repeat (100) @(posedge clk);
    #1;
    applyStimulus(8'd0, 1'b0);
`ifdef MAG_TRACK_DECAY_EN
    checkOutput("decay_saturated", out_peak, 0);
`else
    checkOutput("peak_held", out_peak, 5);
`endif
    @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mag_envelope_tracker.md
MAG_ENVELOPE_TRACKER -- requirements
Module: mag_envelope_tracker

Interface
REQ-001 SHALL have parameter AVG_LOG2, default 3, meaning the log2 of the boxcar average window (window = 8 samples).
REQ-002 SHALL have parameter DECAY_PERIOD, default 16, meaning the cycles between peak decrements (used only with REQ-030).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit: an 8-bit magnitude sample from the upstream sqrt stage is present.
REQ-006 SHALL have port in_mag, input, 8 bits: the unsigned magnitude sample.
REQ-007 SHALL have port in_ready, output, 1 bit: the block can accept a sample this cycle.
REQ-008 SHALL have ports thresh_hi and thresh_lo, input, 8 bits each: the hysteresis thresholds, unsigned.
REQ-009 SHALL have port clr_peak, input, 1 bit: single-cycle request to clear the peak hold.
REQ-010 SHALL have port out_valid, output, 1 bit: a result beat is present.
REQ-011 SHALL have port out_ready, input, 1 bit: downstream accepts the beat.
REQ-012 SHALL have ports out_peak and out_avg, output, 8 bits each: the peak hold and the boxcar mean.
REQ-013 SHALL have ports out_above, out_rise and out_fall, output, 1 bit each: the hysteresis state, the below-to-above crossing flag and the above-to-below crossing flag for this beat.

Function
REQ-014 SHALL accept a sample when in_valid && in_ready; in_ready = !out_valid || out_ready (single output register, no combinational in->out path).
REQ-015 SHALL present the results for an accepted sample with out_valid=1 on the next cycle (latency 1); out_* SHALL hold stable while out_valid && !out_ready.
REQ-016 SHALL clear out_valid when out_ready=1 and no new sample is accepted in the same cycle.
REQ-017 SHALL keep a 2^AVG_LOG2-deep sample history (zero-filled at reset) and a running sum of width 8+AVG_LOG2; sum_next = sum + in_mag - oldest; it SHALL never overflow.
REQ-018 SHALL compute out_avg = sum_next >> AVG_LOG2 (truncating); before the window has filled, zeros count as samples.
REQ-019 SHALL update the peak to max(peak, in_mag) on each accepted sample.
REQ-020 SHALL set the peak to 0 on clr_peak with no sample accepted; with clr_peak and an accepted sample in the same cycle, the peak SHALL equal that sample.
REQ-021 SHALL implement a two-state FSM with states BELOW and ABOVE, evaluated only on accepted samples: BELOW->ABOVE when in_mag >= thresh_hi; ABOVE->BELOW when in_mag < thresh_lo; otherwise hold.
REQ-022 SHALL set out_rise (or out_fall) for exactly the beat whose sample caused the transition; both SHALL be 0 on all other beats; out_above SHALL reflect the state after the sample.
REQ-023 SHALL use thresholds as sampled in the accept cycle; if thresh_lo > thresh_hi, the comparisons still apply literally (oscillation allowed, not an error).

Reset
REQ-024 SHALL, on rst=1 at a clock edge, set out_valid=0, out_peak=0, out_avg=0, out_above=0, out_rise=0, out_fall=0, sum=0, all history entries=0, FSM=BELOW and the decay counter=0.
REQ-025 SHALL drive in_ready=1 in the cycle after reset; rst SHALL discard any in-flight beat.

Configuration
REQ-026 SHALL compile peak decay in only when macro MAG_TRACK_DECAY_EN is defined.
REQ-027 SHALL, with MAG_TRACK_DECAY_EN defined, count clock cycles in which the peak does not change; at DECAY_PERIOD the peak SHALL decrement by 1 (saturating at 0) and the count SHALL restart. A new peak or clr_peak SHALL zero the counter.
REQ-028 SHALL, without MAG_TRACK_DECAY_EN, hold the peak indefinitely and SHALL contain no counter logic.
REQ-029 SHALL NOT change out_peak while a beat is stalled; a decay is reflected in the next beat.
REQ-030 DECAY_PERIOD SHALL be ignored unless MAG_TRACK_DECAY_EN is defined.

Structure
REQ-031 SHALL take MAG_W=8, the AVG_LOG2 default and the BELOW/ABOVE state enum from the shared package mag_pkg.
REQ-032 SHALL place the history buffer and the running sum in sub-module mag_boxcar.

Verification
REQ-033 Reset -> all outputs are 0, in_ready=1, state is BELOW.
REQ-034 Eight samples of 80 with out_ready=1 -> out_avg steps 10,20,...,80 and out_peak=80; a ninth sample of 0 -> out_avg=70.
REQ-035 thresh_hi=100, thresh_lo=60, samples 50,100,70,59,100 -> out_rise on beats 2 and 5, out_fall on beat 4, out_above=0,1,1,0,1.
REQ-036 out_ready=0 for 5 cycles with in_valid=1 -> exactly one beat is held stable, in_ready=0, and no samples are lost after release.
REQ-037 Peak 200 then clr_peak coincident with sample 30 -> out_peak=30; clr_peak alone -> next beat peak is that sample.
REQ-038 With MAG_TRACK_DECAY_EN, peak 5 and no further samples for 100 cycles (DECAY_PERIOD=16) -> next beat out_peak=0 (saturated).
